// File: rtl/args_rr_arb.sv
// -----------------------------------------------------------------------------
// args_rr_arb
//
// Round-robin burst arbiter that shares one W-bit argument path among N
// requesters, followed by a single registered output stage (one cycle from
// accept to out_valid, full throughput when out_ready stays high).
//
// A requester that wins in IDLE with req_last=0 locks the path and keeps it
// until it delivers a beat with req_last=1. The round-robin pointer advances
// only on a last-beat accept, so single-beat and multi-beat bursts rotate
// fairness in the same way.
//
// Parameters
//   W   per-requester argument width in bits
//   N   number of requesters (N >= 2)
//   SW  width of a requester index, $clog2(N)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [N]    per-requester beat valid
//   req_last   [N]    per-requester last-beat flag, qualified by req_valid
//   req_data   [W*N]  packed arguments, requester i at [i*W +: W]
//   req_ready  [N]    per-requester accept, at most one bit high
//   out_valid         registered output beat valid
//   out_data   [W]    registered selected argument
//   out_last          registered copy of the accepted req_last
//   out_src    [SW]   registered index of the requester that supplied the beat
//   out_ready         downstream accept of the output beat
//   busy              high while a burst holds the lock or a beat is pending
// -----------------------------------------------------------------------------
module args_rr_arb #(
    parameter int unsigned  W  = 10,
    parameter int unsigned  N  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_last,
    input  logic [W*N-1:0]  req_data,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready,
    output logic            busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] owner;

    logic          free;
    logic          gnt_found;
    logic [SW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          gnt_last;
    logic [W-1:0]  gnt_data;
    logic          accept;
    logic [SW-1:0] ptr_inc;

    // Output stage can take a new beat when empty or draining this cycle.
    assign free = !out_valid || out_ready;

    // Grant selection. In LOCK the owner keeps the grant even if it has
    // dropped req_valid, so the path stays reserved for the rest of its
    // burst. In IDLE the search starts at ptr and wraps modulo N, so
    // indices >= N can never be produced for non-power-of-two N.
    // Reset suppresses the grant so rst always wins over an accept.
    always_comb begin
        int unsigned   cand;
        logic [SW-1:0] cand_idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (rst) begin
            gnt_found = 1'b0;
        end else if (state == ST_LOCK) begin
            gnt_found = 1'b1;
            gnt_idx   = owner;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                cand     = (int'(ptr) + k) % N;
                cand_idx = SW'(cand);
                if (!gnt_found && req_valid[cand_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand_idx;
                end
            end
        end
    end

    // Select the granted requester's signals.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*W +: W];
            end
        end
    end

    // Only the granted requester ever sees ready, and only when the stage
    // can accept; this keeps req_ready one-hot or zero.
    always_comb begin
        req_ready = '0;
        if (gnt_found && free) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (gnt_idx == SW'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign accept = gnt_found && gnt_valid && free;

    // Explicit wrap so non-power-of-two N returns to 0 after N-1.
    always_comb begin
        if (gnt_idx == SW'(N - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = gnt_idx + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_last  <= gnt_last;
                out_src   <= gnt_idx;
                if (gnt_last) begin
                    state <= ST_IDLE;
                    ptr   <= ptr_inc;
                end else begin
                    state <= ST_LOCK;
                    owner <= gnt_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_LOCK) || out_valid;

endmodule

// File: tb/tb_args_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_args_rr_arb
//
// Directed testbench for args_rr_arb (W=10, N=4). Inputs are driven 1 ns
// after the rising edge; registered outputs are checked right after that
// edge and combinational req_ready another 1 ns later.
// -----------------------------------------------------------------------------
module tb_args_rr_arb;

    localparam int unsigned W  = 10;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = $clog2(N);

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [W*N-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            out_ready;
    logic            busy;

    int unsigned checks;
    int unsigned errors;

    args_rr_arb #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned idx, input logic [W-1:0] val);
        req_data[idx*W +: W] = val;
    endtask

    initial begin
        int unsigned exp_src [5] = '{0, 1, 2, 3, 0};
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_last",  out_last,  0);
        check("rst_out_src",   out_src,   0);
        rst = 1'b0;
        #1;
        check("rst_busy",      busy,      0);
        check("rst_req_ready", req_ready, 0);

        // ---------------- all requesters, single-beat bursts ----------------
        for (int i = 0; i < 4; i++) set_data(i, 10'h100 + 10'(i));
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", req_ready, 32'd1 << exp_src[k]);
            tick();
            check("rr_src",   out_src,   exp_src[k]);
            check("rr_valid", out_valid, 1);
            check("rr_data",  out_data,  32'h100 + exp_src[k]);
        end
        req_valid = '0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_src",   out_src,   0);
        check("drain_data",  out_data,  32'h100);

        // ---------------- 3-beat burst from requester 2 ----------------
        // ptr is 1; a single beat from requester 1 moves it to 2.
        req_valid = 4'b0010;
        tick();
        check("pre_burst_src", out_src, 1);
        req_valid = 4'b1111;
        req_last  = 4'b1011;
        for (int b = 0; b < 3; b++) begin
            set_data(2, 10'h2A0 + 10'(b));
            if (b == 2) req_last = 4'b1111;
            #1;
            check("burst_ready", req_ready, 4'b0100);
            tick();
            check("burst_src",  out_src,  2);
            check("burst_data", out_data, 32'h2A0 + 32'(b));
            check("burst_last", out_last, (b == 2) ? 1 : 0);
            check("burst_busy", busy,     1);
        end
        #1;
        check("post_burst_ready", req_ready, 4'b1000);
        tick();
        check("post_burst_src", out_src, 3);
        req_valid = '0;
        tick();
        check("post_burst_drain", out_valid, 0);

        // ---------------- back-pressure hold ----------------
        // ptr is 0; requester 1 alone wins.
        set_data(1, 10'h155);
        req_valid = 4'b0010;
        #1;
        check("bp_first_ready", req_ready, 4'b0010);
        tick();
        check("bp_first_data", out_data, 32'h155);
        out_ready = 1'b0;
        set_data(1, 10'h0AA);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_stall_ready", req_ready, 0);
            tick();
            check("bp_hold_data",  out_data,  32'h155);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_src",   out_src,   1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'b0010);
        tick();
        check("bp_new_data",  out_data,  32'h0AA);
        check("bp_new_valid", out_valid, 1);
        req_valid = '0;
        tick();
        check("bp_drain", out_valid, 0);

        // ---------------- pointer wrap 3 -> 0 ----------------
        // ptr is 2; a single beat from requester 2 moves it to 3.
        req_valid = 4'b0100;
        tick();
        check("wrap_pre_src", out_src, 2);
        req_valid = 4'b1001;
        #1;
        check("wrap_ready3", req_ready, 4'b1000);
        tick();
        check("wrap_src3", out_src, 3);
        #1;
        check("wrap_ready0", req_ready, 4'b0001);
        tick();
        check("wrap_src0", out_src, 0);
        req_valid = 4'b1111;
        #1;
        check("wrap_ptr_is_1", req_ready, 4'b0010);
        req_valid = '0;
        tick();

        // ---------------- lock held while owner idles, then reset ----------------
        set_data(1, 10'h3C3);
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        #1;
        check("lock_first_ready", req_ready, 4'b0010);
        tick();
        check("lock_first_src", out_src, 1);
        out_ready = 1'b0;
        req_valid = 4'b1101;
        #1;
        check("lock_stall_ready", req_ready, 0);
        repeat (2) begin
            tick();
            check("lock_busy",  busy,      1);
            check("lock_valid", out_valid, 1);
            check("lock_data",  out_data,  32'h3C3);
        end
        out_ready = 1'b1;
        #1;
        check("lock_owner_absent_ready", req_ready, 4'b0010);
        tick();
        check("lock_drain_valid", out_valid, 0);
        check("lock_drain_busy",  busy,      1);
        req_valid = 4'b1111;
        #1;
        check("lock_others_blocked", req_ready, 4'b0010);
        tick();
        check("lock_second_src",   out_src,   1);
        check("lock_second_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_busy",  busy,      0);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("midrst_ready", req_ready, 0);
        set_data(0, 10'h0F0);
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        #1;
        check("after_rst_ready", req_ready, 4'b0001);
        tick();
        check("after_rst_src",   out_src,   0);
        check("after_rst_data",  out_data,  32'h0F0);
        check("after_rst_valid", out_valid, 1);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
